// File: rtl/wb_sram_stream_reader.sv
// Wishbone burst reader: drains a contiguous SRAM byte range into a valid/ready byte stream
// through a small prefetch FIFO, issuing requests only when FIFO space is guaranteed.
module wb_sram_stream_reader #(
    parameter int unsigned ABITS = 12,
    parameter int unsigned FBITS = 2,
    parameter int unsigned DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [ABITS-1:0] base_i,
    input  logic [ABITS:0]   count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic             bst_o,
    output logic [ABITS-1:0] adr_o,
    input  logic             ack_i,
    input  logic             wat_i,
    input  logic [7:0]       dat_i,
    output logic [7:0]       dat_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned DEPTH = 1 << FBITS;
    localparam int unsigned CW    = ABITS + 1;
    localparam int unsigned PW    = FBITS + 1;

    // DELAY only ever shaped simulated register timing; registers here update without delay.
    if (DELAY > 0) begin : g_sim_delay
    end

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFinish} state_e;

    state_e           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    issued_q, issued_d;
    logic [CW-1:0]    acked_q, acked_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [7:0]       mem_q [DEPTH];

    logic [PW-1:0] level;
    logic [CW-1:0] outstanding;
    logic          fifo_empty;
    logic          in_fetch;
    logic          issue;
    logic          last_req;
    logic          push;
    logic          pop;
    logic          flush;

    assign level       = wptr_q - rptr_q;
    assign fifo_empty  = (level == '0);
    assign outstanding = issued_q - acked_q;
    assign in_fetch    = (state_q == StFetch);
    assign last_req    = ((issued_q + CW'(1)) == count_q);

    // Credit rule: every byte in flight or buffered owns a FIFO slot, so acks can never overflow.
    assign issue = in_fetch && !abort_i && !wat_i && (issued_q < count_q) &&
                   ((CW'(level) + outstanding) < CW'(DEPTH));

    // Stray acks (e.g. late acks of an aborted transfer) are ignored when nothing is in flight.
    assign push  = in_fetch && ack_i && (outstanding != '0);
    assign pop   = !fifo_empty && ready_i;
    assign flush = abort_i && ((state_q == StFetch) || (state_q == StDrain));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        issued_d = issued_q;
        acked_d  = acked_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;

        if (push) begin
            wptr_d  = wptr_q + PW'(1);
            acked_d = acked_q + CW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (issue) begin
            addr_d   = addr_q + ABITS'(1);
            issued_d = issued_q + CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    if (count_i != '0) begin
                        state_d  = StFetch;
                        addr_d   = base_i;
                        count_d  = count_i;
                        issued_d = '0;
                        acked_d  = '0;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFetch: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (acked_d == count_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (fifo_empty) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            acked_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            acked_q  <= acked_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[FBITS-1:0]] <= dat_i;
        end
    end

    assign cyc_o   = in_fetch;
    assign stb_o   = issue;
    assign bst_o   = issue && !last_req;
    assign we_o    = 1'b0;
    assign adr_o   = addr_q;
    assign busy_o  = (state_q == StFetch) || (state_q == StDrain);
    assign done_o  = (state_q == StFinish);
    assign valid_o = !fifo_empty;
    assign dat_o   = fifo_empty ? 8'h00 : mem_q[rptr_q[FBITS-1:0]];

endmodule

// File: doc/wb_sram_stream_reader.md
Name: wb_sram_stream_reader

Overview:
Wishbone master that drains a contiguous byte range from the 8-bit port of the dual-port visibilities SRAM. It presents the bytes as a valid/ready stream to the SPI transmit path. It is the downstream consumer of the SRAM. It issues pipelined burst reads, buffers the returned bytes in a small prefetch FIFO, and throttles requests so that no acknowledged byte is ever dropped.

Parameters:
ABITS, 12, byte-address width of the SRAM 8-bit port
FBITS, 2, log2 of prefetch FIFO depth (DEPTH = 1<<FBITS)
DELAY, 3, simulation-only delay on registered assignments

Ports:
clk_i  in  1  bus clock
rst_ni  in  1  asynchronous reset, active-low
start_i  in  1  single-cycle pulse: begin transfer
abort_i  in  1  synchronous abort of the transfer in progress
base_i  in  ABITS  start byte address, sampled on start_i
count_i  in  ABITS+1  byte count, sampled on start_i (0..2^ABITS)
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse: all bytes delivered
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  constant 0
bst_o  out  1  burst continues after this request
adr_o  out  ABITS  byte address
ack_i  in  1  Wishbone acknowledge
wat_i  in  1  Wishbone wait/stall
dat_i  in  8  read data, valid with ack_i
dat_o  out  8  stream byte
valid_o  out  1  dat_o valid
ready_i  in  1  consumer accepts dat_o

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous and active-low.
- Reset state: all outputs 0, FIFO empty, FSM in IDLE. Reset asserted mid-transfer discards everything, with no done_o.
- FSM states: IDLE, FETCH, DRAIN, FINISH.
- IDLE:
  - start_i with count_i != 0: latch base/count, go to FETCH, busy_o = 1 from the next cycle.
  - start_i with count_i == 0: go to FINISH directly, with no bus activity.
- FETCH:
  - cyc_o = 1 throughout.
  - stb_o = 1 when issued < count, fifo_level + outstanding < DEPTH, and wat_i = 0.
  - Each issued strobe advances adr_o by 1, modulo 2^ABITS (wrap-around allowed).
  - outstanding = issued - acked.
- bst_o: equals stb_o on every request except the final one of the transfer, where it is 0. This satisfies the SRAM rule that burst deasserts one cycle before the last ack.
- Ack handling:
  - Each ack_i pushes dat_i into the FIFO.
  - Acks arrive one cycle after the strobe; the logic must also tolerate later acks.
  - The credit rule guarantees the FIFO never overflows.
- FETCH exit: when acked == count, drop cyc_o/stb_o/bst_o in the same cycle the final ack is registered, then go to DRAIN.
- DRAIN: wait until the FIFO is empty, then go to FINISH.
- FINISH:
  - done_o = 1 for exactly one cycle, busy_o = 0 in that cycle.
  - Return to IDLE.
- Stream output:
  - valid_o = !fifo_empty.
  - A byte is consumed when valid_o && ready_i.
  - dat_o holds stable while valid_o && !ready_i.
  - Push and pop in the same cycle leave the level unchanged.
- Latency, with ready_i = 1:
  - start_i at cycle 0.
  - First stb_o at cycle 1.
  - First ack at cycle 2.
  - First valid_o at cycle 3.
  - Throughput 1 byte/cycle in steady state.
- Credit and stall:
  - With ready_i = 0, at most DEPTH requests are issued, then stb_o holds 0.
  - wat_i = 1 suppresses new strobes and does not drop cyc_o.
- start_i while busy_o = 1: ignored.
- abort_i in FETCH or DRAIN:
  - Next cycle: cyc_o, stb_o, valid_o and busy_o = 0, FIFO flushed, FSM in IDLE.
  - No done_o.
  - Acks for in-flight requests arriving after the abort are ignored.
- abort_i in IDLE: no effect.
- abort_i and start_i in the same cycle in IDLE: abort wins.
- Counters are ABITS+1 bits wide, so count = 2^ABITS reads the entire memory once.

Test Plan:
1. SRAM bytes 0x010..0x013 = A0,A1,A2,A3; start base=0x010 count=4, ready_i=1 -> stb_o on 4 consecutive cycles, bst_o = 1,1,1,0; stream A0,A1,A2,A3 with the first valid at cycle 3; done_o pulse once; cyc_o low afterwards.
2. count=10, ready_i=0 for 20 cycles then 1 -> exactly 4 strobes before the stall; then all 10 bytes delivered in address order with no loss or duplication.
3. base=0xFFE count=4 -> adr_o sequence FFE, FFF, 000, 001; data matches those locations.
4. count=0 -> done_o one cycle after start_i; cyc_o never asserted; busy_o never 1.
5. wat_i held high for 3 cycles mid-burst, then a second start_i issued while busy -> strobes pause and then resume at the correct address; the second start_i is ignored; exactly 1 done_o.
6. abort_i two cycles into count=8 -> cyc_o/valid_o/busy_o low next cycle, no done_o. Then rst_ni is pulsed low asynchronously during a fresh transfer -> all outputs immediately 0.
